// File: rtl/driver_teclado_pkg.sv
// Shared key codes and scanner FSM encoding for the 4x4 keypad driver.
package driver_teclado_pkg;

  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] KEY_A    = 5'd10;
  localparam logic [CODE_W-1:0] KEY_B    = 5'd11;
  localparam logic [CODE_W-1:0] KEY_C    = 5'd12;
  localparam logic [CODE_W-1:0] KEY_D    = 5'd13;
  localparam logic [CODE_W-1:0] KEY_STAR = 5'd14;
  localparam logic [CODE_W-1:0] KEY_HASH = 5'd15;
  localparam logic [CODE_W-1:0] KEY_NONE = 5'h1F;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/driver_teclado.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces a press,
// latches its key code and pulses enter for '#'.
module driver_teclado
  import driver_teclado_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1,
  parameter int unsigned DEBOUNCE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [4:0] digito,
  output logic       enter
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  state_t              state_q, state_d;
  logic [3:0]          col_q, col_d;
  logic [CODE_W-1:0]   digito_q, digito_d;
  logic                enter_q, enter_d;
  logic [3:0]          cap_q, cap_d;
  logic [DB_W-1:0]     db_q, db_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CODE_W-1:0]   code_c;
  logic [3:0]          col_next_c;

  // (row,col) -> key code; lowest set row wins when several rows are high.
  function automatic logic [CODE_W-1:0] key_code(input logic [3:0] rows,
                                                 input logic [3:0] cols);
    logic [1:0] r;
    logic [1:0] c;
    casez (rows)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      default: r = 2'd3;
    endcase
    case (cols)
      4'b0001: c = 2'd0;
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      default: c = 2'd3;
    endcase
    case ({r, c})
      4'd0:    key_code = 5'd1;
      4'd1:    key_code = 5'd2;
      4'd2:    key_code = 5'd3;
      4'd3:    key_code = KEY_A;
      4'd4:    key_code = 5'd4;
      4'd5:    key_code = 5'd5;
      4'd6:    key_code = 5'd6;
      4'd7:    key_code = KEY_B;
      4'd8:    key_code = 5'd7;
      4'd9:    key_code = 5'd8;
      4'd10:   key_code = 5'd9;
      4'd11:   key_code = KEY_C;
      4'd12:   key_code = KEY_STAR;
      4'd13:   key_code = 5'd0;
      4'd14:   key_code = KEY_HASH;
      default: key_code = KEY_D;
    endcase
  endfunction

  // In SCAN the live sample is the one being accepted; later the captured one is.
  assign code_c     = key_code((state_q == ST_SCAN) ? fila : cap_q, col_q);
  assign col_next_c = {col_q[2:0], col_q[3]};

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    digito_d = digito_q;
    enter_d  = 1'b0;
    cap_d    = cap_q;
    db_d     = db_q;
    div_d    = div_q;
    case (state_q)
      ST_SCAN: begin
        if (fila != 4'b0000) begin
          cap_d = fila;
          div_d = '0;
          if (DEBOUNCE == 1) begin
            digito_d = code_c;
            enter_d  = (code_c == KEY_HASH);
            db_d     = '0;
            state_d  = ST_HOLD;
          end else begin
            db_d    = DB_W'(1);
            state_d = ST_CONFIRM;
          end
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d = '0;
          col_d = col_next_c;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (fila == cap_q) begin
          if (db_q + DB_W'(1) == DB_W'(DEBOUNCE)) begin
            digito_d = code_c;
            enter_d  = (code_c == KEY_HASH);
            db_d     = '0;
            state_d  = ST_HOLD;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          db_d    = '0;
          col_d   = col_next_c;
          state_d = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (fila == 4'b0000) begin
          if (db_q + DB_W'(1) == DB_W'(DEBOUNCE)) begin
            db_d    = '0;
            col_d   = col_next_c;
            state_d = ST_SCAN;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          db_d = '0;
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SCAN;
      col_q    <= 4'b0001;
      digito_q <= KEY_NONE;
      enter_q  <= 1'b0;
      cap_q    <= '0;
      db_q     <= '0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      digito_q <= digito_d;
      enter_q  <= enter_d;
      cap_q    <= cap_d;
      db_q     <= db_d;
      div_q    <= div_d;
    end
  end

  assign col    = col_q;
  assign digito = digito_q;
  assign enter  = enter_q;

endmodule

// File: tb/tb_driver_teclado.sv
// Scoreboard bench for driver_teclado: one instance with DEBOUNCE=1, one with DEBOUNCE=3.
module tb_driver_teclado;

  typedef struct packed {
    logic [4:0] dig;
    logic       ent;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fila1, fila3;
  logic [3:0] col1, col3;
  logic [4:0] digito1, digito3;
  logic       enter1, enter3;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q1[$];
  exp_t q3[$];
  logic [4:0] prev1 = 5'h1F;
  logic [4:0] prev3 = 5'h1F;

  always #5 clk = ~clk;

  driver_teclado #(.SCAN_DIV(1), .DEBOUNCE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fila(fila1),
    .col(col1), .digito(digito1), .enter(enter1)
  );

  driver_teclado #(.SCAN_DIV(1), .DEBOUNCE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .fila(fila3),
    .col(col3), .digito(digito3), .enter(enter3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input bit which, input logic [3:0] tgt);
    for (int i = 0; i < 8; i++) begin
      if ((which ? col3 : col1) == tgt) break;
      tick();
    end
    check(which ? "wait_col3" : "wait_col1", 32'(which ? col3 : col1), 32'(tgt));
  endtask

  // Accept monitor: a digito change or an enter pulse is one DUT output event.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      prev1 = digito1;
      prev3 = digito3;
    end else begin
      if (digito1 !== prev1 || enter1) begin
        if (q1.size() == 0) check("spurious_accept1", 32'(q1.size()), 32'd1);
        else begin
          e = q1.pop_front();
          check("digito1", 32'(digito1), 32'(e.dig));
          check("enter1", 32'(enter1), 32'(e.ent));
        end
      end
      if (digito3 !== prev3 || enter3) begin
        if (q3.size() == 0) check("spurious_accept3", 32'(q3.size()), 32'd1);
        else begin
          e = q3.pop_front();
          check("digito3", 32'(digito3), 32'(e.dig));
          check("enter3", 32'(enter3), 32'(e.ent));
        end
      end
      prev1 = digito1;
      prev3 = digito3;
    end
  end

  initial begin
    logic [3:0] exp_col;
    rst_n = 1'b0;
    fila1 = 4'b0000;
    fila3 = 4'b0000;
    repeat (2) tick();

    // Reset values
    check("rst_col", 32'(col1), 32'h1);
    check("rst_digito", 32'(digito1), 32'h1F);
    check("rst_enter", 32'(enter1), 32'h0);
    check("rst_col3", 32'(col3), 32'h1);
    rst_n = 1'b1;

    // Free-running column rotation with no key
    exp_col = 4'b0001;
    check("scan_start", 32'(col1), 32'(exp_col));
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_col = {exp_col[2:0], exp_col[3]};
      check("scan_col", 32'(col1), 32'(exp_col));
      check("scan_digito", 32'(digito1), 32'h1F);
      check("scan_enter", 32'(enter1), 32'h0);
    end

    // One-clock press of row 0 on column 1 -> '2'
    wait_col(1'b0, 4'b0010);
    fila1 = 4'b0001;
    q1.push_back('{dig: 5'd2, ent: 1'b0});
    tick();
    check("k2_col_frozen", 32'(col1), 32'h2);
    check("k2_enter", 32'(enter1), 32'h0);
    fila1 = 4'b0000;
    tick();
    check("k2_resume", 32'(col1), 32'h4);

    // '#' (row 3, column 2) -> code 15 with a single-cycle enter
    wait_col(1'b0, 4'b0100);
    fila1 = 4'b1000;
    q1.push_back('{dig: 5'd15, ent: 1'b1});
    tick();
    check("hash_enter_hi", 32'(enter1), 32'h1);
    fila1 = 4'b0000;
    tick();
    check("hash_enter_lo", 32'(enter1), 32'h0);

    // Held key '4' (row 1, column 0): one accept, column frozen until release
    wait_col(1'b0, 4'b0001);
    fila1 = 4'b0010;
    q1.push_back('{dig: 5'd4, ent: 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("k4_hold_col", 32'(col1), 32'h1);
    end
    fila1 = 4'b0000;
    tick();
    check("k4_release_col", 32'(col1), 32'h2);

    // Rows 0 and 2 together on column 3: row 0 wins -> 'A'
    wait_col(1'b0, 4'b1000);
    fila1 = 4'b0101;
    q1.push_back('{dig: 5'd10, ent: 1'b0});
    tick();
    check("kA_enter", 32'(enter1), 32'h0);
    fila1 = 4'b0000;
    tick();

    // DEBOUNCE=3: 2-clock glitch rejected, 3-clock press accepted as '7'
    wait_col(1'b1, 4'b0001);
    fila3 = 4'b0100;
    tick();
    check("glitch_col_a", 32'(col3), 32'h1);
    tick();
    check("glitch_col_b", 32'(col3), 32'h1);
    fila3 = 4'b0000;
    tick();
    check("glitch_digito", 32'(digito3), 32'h1F);
    check("glitch_advance", 32'(col3), 32'h2);
    wait_col(1'b1, 4'b0001);
    fila3 = 4'b0100;
    q3.push_back('{dig: 5'd7, ent: 1'b0});
    tick();
    check("db3_lat1", 32'(digito3), 32'h1F);
    tick();
    check("db3_lat2", 32'(digito3), 32'h1F);
    tick();
    check("db3_accept", 32'(digito3), 32'h7);
    fila3 = 4'b0000;
    tick();
    tick();
    check("db3_rel_frozen", 32'(col3), 32'h1);
    tick();
    check("db3_rel_done", 32'(col3), 32'h2);

    // Asynchronous reset while holding '3' (row 0, column 2)
    wait_col(1'b0, 4'b0100);
    fila1 = 4'b0001;
    q1.push_back('{dig: 5'd3, ent: 1'b0});
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_col", 32'(col1), 32'h1);
    check("arst_digito", 32'(digito1), 32'h1F);
    check("arst_enter", 32'(enter1), 32'h0);
    fila1 = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_digito", 32'(digito1), 32'h1F);

    // Every expected accept must have been observed
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
